// File: rtl/tdm_demux_2ch.sv
// Two-channel TDM demultiplexer: steers an interleaved sample stream into registered
// per-channel outputs, tracking slot alignment and counting dropped samples.
module tdm_demux_2ch #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             y0_valid,
    output logic             y1_valid,
    output logic             pair_valid,
    output logic             sync_err,
    output logic             locked,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP1 = 2'd1,
        EXP0 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;

    // Pulses default low every cycle; only an accepted sample raises them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            y0         <= '0;
            y1         <= '0;
            y0_valid   <= 1'b0;
            y1_valid   <= 1'b0;
            pair_valid <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            y0_valid   <= 1'b0;
            y1_valid   <= 1'b0;
            pair_valid <= 1'b0;
            sync_err   <= 1'b0;
            if (din_valid) begin
                case (state)
                    IDLE: begin
                        if (frame_sync) begin
                            y0       <= din;
                            y0_valid <= 1'b1;
                            state    <= EXP1;
                            locked   <= 1'b1;
                        end else if (drop_cnt != CNT_MAX) begin
                            drop_cnt <= drop_cnt + 1'b1;
                        end
                    end
                    EXP1: begin
                        if (frame_sync) begin
                            // Slot 1 went missing: restart the frame on this sample.
                            sync_err <= 1'b1;
                            y0       <= din;
                            y0_valid <= 1'b1;
                        end else begin
                            y1         <= din;
                            y1_valid   <= 1'b1;
                            pair_valid <= 1'b1;
                            state      <= EXP0;
                        end
                    end
                    EXP0: begin
                        if (frame_sync) begin
                            y0       <= din;
                            y0_valid <= 1'b1;
                            state    <= EXP1;
                        end else begin
                            sync_err <= 1'b1;
                            if (drop_cnt != CNT_MAX) begin
                                drop_cnt <= drop_cnt + 1'b1;
                            end
                            state  <= IDLE;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// Scoreboard bench for tdm_demux_2ch: a frame-level reference model predicts every
// pulse cycle, and an independent monitor compares whenever the DUT pulses.
module tb_tdm_demux_2ch;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic             y0_valid;
    logic             y1_valid;
    logic             pair_valid;
    logic             sync_err;
    logic             locked;
    logic [CNT_W-1:0] drop_cnt;

    tdm_demux_2ch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .y0(y0), .y1(y1), .y0_valid(y0_valid),
        .y1_valid(y1_valid), .pair_valid(pair_valid), .sync_err(sync_err),
        .locked(locked), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int y0;
        int y1;
        bit y0v;
        bit y1v;
        bit pv;
        bit se;
        bit lk;
        int drops;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: frame-level view of the stream
    bit aligned;
    bit have_slot0;
    int m_y0;
    int m_y1;
    int m_drops;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        aligned    = 1'b0;
        have_slot0 = 1'b0;
        m_y0       = 0;
        m_y1       = 0;
        m_drops    = 0;
        exp_q.delete();
    endtask

    task automatic countDrop();
        if (m_drops < CNT_MAX) m_drops++;
    endtask

    // Present one valid sample for one clock; the model predicts its effect.
    task automatic applyStimulus(input int data, input bit sync);
        exp_t e;
        bit   pulse;
        e = '{default: 0};
        pulse = 1'b0;
        if (sync) begin
            e.se = aligned && have_slot0;
            m_y0 = data;
            e.y0v = 1'b1;
            aligned = 1'b1;
            have_slot0 = 1'b1;
            pulse = 1'b1;
        end else if (aligned && have_slot0) begin
            m_y1 = data;
            e.y1v = 1'b1;
            e.pv = 1'b1;
            have_slot0 = 1'b0;
            pulse = 1'b1;
        end else if (aligned) begin
            e.se = 1'b1;
            countDrop();
            aligned = 1'b0;
            pulse = 1'b1;
        end else begin
            countDrop();
        end
        e.y0 = m_y0;
        e.y1 = m_y1;
        e.lk = aligned;
        e.drops = m_drops;
        if (pulse) exp_q.push_back(e);
        din        = data[WIDTH-1:0];
        frame_sync = sync;
        din_valid  = 1'b1;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        din_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            frame_sync = $urandom_range(0, 1) != 0;
            din        = WIDTH'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, " y0"}, int'(y0), 0);
        checkOutput({tag, " y1"}, int'(y1), 0);
        checkOutput({tag, " pulses"}, int'({y0_valid, y1_valid, pair_valid, sync_err}), 0);
        checkOutput({tag, " locked"}, int'(locked), 0);
        checkOutput({tag, " drop_cnt"}, int'(drop_cnt), 0);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
    task automatic doReset();
        rst_n = 1'b0;
        din_valid = 1'b0;
        #1;
        checkZeroOutputs("reset");
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (y0_valid || y1_valid || pair_valid || sync_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse actual=%b expected=0000",
                         {y0_valid, y1_valid, pair_valid, sync_err});
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("y0", int'(y0), e.y0);
                checkOutput("y1", int'(y1), e.y1);
                checkOutput("y0_valid", int'(y0_valid), int'(e.y0v));
                checkOutput("y1_valid", int'(y1_valid), int'(e.y1v));
                checkOutput("pair_valid", int'(pair_valid), int'(e.pv));
                checkOutput("sync_err", int'(sync_err), int'(e.se));
                checkOutput("locked", int'(locked), int'(e.lk));
                checkOutput("drop_cnt", int'(drop_cnt), e.drops);
            end
        end
    end

    task automatic drainAndCheck(input string tag);
        idleCycles(3);
        checkOutput({tag, " pending"}, exp_q.size(), 0);
        exp_q.delete();
        checkOutput({tag, " locked"}, int'(locked), int'(aligned));
        checkOutput({tag, " drop_cnt"}, int'(drop_cnt), m_drops);
    endtask

    initial begin
        rst_n      = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = '0;
        modelReset();
        #2;
        checkZeroOutputs("initial");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] aligned frames");
        applyStimulus(8'hA1, 1); applyStimulus(8'hB2, 0);
        applyStimulus(8'hA3, 1); applyStimulus(8'hB4, 0);
        drainAndCheck("aligned");

        $display("[TB] drops before first sync");
        doReset();
        applyStimulus(8'h11, 0); applyStimulus(8'h22, 0);
        applyStimulus(8'h33, 1); applyStimulus(8'h44, 0);
        drainAndCheck("presync");

        $display("[TB] resync in slot 1 and extra sample");
        applyStimulus(8'h55, 1); applyStimulus(8'h66, 1); applyStimulus(8'h77, 0);
        applyStimulus(8'h88, 0);
        drainAndCheck("faults");

        $display("[TB] gapped stream");
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'h20 + i, (i % 2) == 0);
            idleCycles($urandom_range(0, 3));
        end
        drainAndCheck("gaps");

        $display("[TB] reset mid-frame");
        applyStimulus(8'hC1, 1);
        doReset();
        applyStimulus(8'hD2, 0);
        idleCycles(2);
        applyStimulus(8'hE3, 1); applyStimulus(8'hF4, 0);
        drainAndCheck("midreset");

        $display("[TB] drop counter saturation");
        doReset();
        for (int i = 0; i < 300; i++) applyStimulus($urandom_range(0, 255), 0);
        drainAndCheck("saturate");

        $display("[TB] random stream");
        doReset();
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 255), $urandom_range(0, 99) < 45);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        end
        drainAndCheck("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux_2ch.md
# tdm_demux_2ch

Two-channel time-division demultiplexer: the receive-side counterpart of the 2:1 channel multiplexer. It takes a single stream of samples carrying two interleaved channels (slot 0 flagged by `frame_sync`) and steers each sample into its own registered channel output, with per-channel valid pulses and a frame-complete pulse. A small state machine tracks slot alignment, drops samples until the first sync, and reports sync faults and drop counts for lab debug.

## Interface
- `WIDTH`, 8, sample width in bits
- `CNT_W`, 8, width of the saturating drop counter
- `clk`  input  1  system clock; all state updates on the rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `din`  input  WIDTH  multiplexed sample
- `din_valid`  input  1  `din` is valid this cycle
- `frame_sync`  input  1  qualified by `din_valid`; marks the sample as slot 0 (channel 0)
- `y0`  output  WIDTH  last channel-0 sample; holds between updates
- `y1`  output  WIDTH  last channel-1 sample; holds between updates
- `y0_valid`  output  1  one-cycle pulse: `y0` updated
- `y1_valid`  output  1  one-cycle pulse: `y1` updated
- `pair_valid`  output  1  one-cycle pulse: `y0`/`y1` form a complete aligned frame
- `sync_err`  output  1  one-cycle pulse: slot misalignment detected
- `locked`  output  1  high while the state is not IDLE
- `drop_cnt`  output  CNT_W  number of dropped samples; saturates at all-ones

## Operation
- States: IDLE (unaligned), EXP1 (slot 0 captured, expecting slot 1), EXP0 (frame complete, expecting slot 0). Reset state is IDLE.
- Cycles with `din_valid`=0 are ignored: no state change and no pulses. `frame_sync` is don't-care when `din_valid`=0.
- IDLE:
  - valid with sync: `y0`<=`din`, pulse `y0_valid`, go to EXP1.
  - valid without sync: drop the sample, increment `drop_cnt`, stay in IDLE.
- EXP1:
  - valid without sync: `y1`<=`din`, pulse `y1_valid` and `pair_valid`, go to EXP0.
  - valid with sync (slot 1 missing): pulse `sync_err`, `y0`<=`din`, pulse `y0_valid`, stay in EXP1 (resync).
- EXP0:
  - valid with sync: `y0`<=`din`, pulse `y0_valid`, go to EXP1.
  - valid without sync (extra sample): pulse `sync_err`, drop it, increment `drop_cnt`, go to IDLE.
- `drop_cnt` saturates at 2^CNT_W-1 and never wraps. It clears only on reset.
- `pair_valid` is never asserted after an EXP1 resync unless a fresh slot 1 follows. `y1` is never written from IDLE or EXP0.

## Timing
- All outputs are registered. A sample accepted at edge N is visible on `y0`/`y1` after edge N, and its pulses are high for exactly the cycle following edge N.
- `pair_valid` coincides with `y1_valid`. At that point `y0` still holds the slot 0 of the same frame.
- Throughput: one sample per cycle. Back-to-back valid cycles are fully supported with no bubbles.
- Reset values (asynchronous, immediate):
  - `y0`=0, `y1`=0
  - `y0_valid`, `y1_valid`, `pair_valid`, `sync_err` = 0
  - `locked`=0, `drop_cnt`=0, state IDLE
- Reset mid-frame discards any partial frame. The first sample after reset release is handled from IDLE.
- `locked` goes high the cycle after the first synced sample is accepted. It goes low the cycle after an EXP0 fault.

## Test plan
- Reset, then valid samples 0xA1(sync), 0xB2, 0xA3(sync), 0xB4 on consecutive cycles -> `y0`=A1, `y1`=B2 with `pair_valid` pulse, then `y0`=A3, `y1`=B4 with a second pulse; `sync_err`=0, `drop_cnt`=0.
- Reset, then 0x11, 0x22 without sync, then 0x33(sync), 0x44 -> first two samples dropped, `drop_cnt`=2, `locked` rises after 0x33, `y0`=33, `y1`=44.
- Aligned, then 0x55(sync), 0x66(sync), 0x77 -> `sync_err` pulse on 0x66, `y0`=66, `y1`=77, one `pair_valid` (for 66/77 only).
- Aligned frame complete, then 0x88 without sync -> `sync_err` pulse, `drop_cnt`+1, `locked`=0, then state IDLE.
- Sync samples with `din_valid` gaps of 0-3 cycles between samples -> outputs identical to the gap-free run; no pulses during gap cycles.
- Assert `rst_n`=0 between slot 0 and slot 1, and separately drive 300 unsynced samples with CNT_W=8 -> all outputs 0 immediately on reset, no `pair_valid` afterward until a fresh sync; `drop_cnt` stops at 255.
